serdes_word_aligner: RTL
========================

// Module: serdes_word_aligner
// PURPOSE
//   Receive-side stage directly downstream of serdes: consumes its recovered parallel
//   words (para_out), finds the sync word at any bit offset, locks on, and emits
//   bit-aligned payload words with a one-cycle valid strobe.
//   Frame on the link: SYNC_WORD, FRAME_LEN payload words, SYNC_WORD, ...
// PARAMETERS
//   WIDTH        8      word width (offset search covers 0..WIDTH-1)
//   SYNC_WORD    8'h81  sync/comma word
//   FRAME_LEN    1      payload words between consecutive sync words (>=1)
//   LOCK_HITS    3      consecutive correctly spaced syncs needed to lock (>=2)
//   LOSS_MISSES  4      consecutive missed syncs that drop lock (>=1)
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high; clears all state
//   in_data    in   WIDTH  raw word from serdes para_out, arbitrary bit offset
//   in_valid   in   1      in_data is a new word this cycle
//   out_data   out  WIDTH  aligned payload word
//   out_valid  out  1      one-cycle strobe, out_data valid
//   locked     out  1      high in LOCKED state
//   offset     out  3      bit offset in use (0 = word already aligned)
//   sync_err   out  1      one-cycle pulse on each missed sync while LOCKED
// BEHAVIOUR
//   Reset values: out_data=0, out_valid=0, locked=0, offset=0, sync_err=0.
//   Internal resets: state=HUNT, prev=0, primed=0, slot=0, hits=0, misses=0.
//   in_valid=0: all state holds; out_valid and sync_err are 0.
//   Window on in_valid: w={prev,in_data} (2*WIDTH bits). Candidate k = w[2*WIDTH-1-k -: WIDTH].
//   After each in_valid, prev<=in_data and primed<=1. No candidate is evaluated while primed=0.
//   The aligned word is therefore always one input word behind.
//   slot counts aligned words since the last sync, 0..FRAME_LEN.
//   When slot wraps to 0, the current aligned word is a sync position.
//   HUNT: on each primed in_valid, scan k=0..WIDTH-1.
//     Lowest matching k wins: offset<=k, slot<=1, hits<=1, go to VERIFY.
//     No match: stay in HUNT.
//   VERIFY: advance slot on each in_valid. At a sync position, compare candidate[offset] with SYNC_WORD:
//     match: hits++; when hits reaches LOCK_HITS go to LOCKED, misses<=0.
//     mismatch: go to HUNT. Scanning resumes on the next in_valid.
//     Payload is not emitted in VERIFY. This rejects false syncs found in payload.
//   LOCKED: at a payload slot, out_data<=candidate[offset] and out_valid<=1 on the clock edge that samples in_valid.
//     At a sync position, match: misses<=0.
//     At a sync position, mismatch: misses++ and sync_err pulses.
//     If misses reaches LOSS_MISSES: go to HUNT, locked<=0, hits<=0.
//     Payload continues to be emitted while misses<LOSS_MISSES.
//   offset holds its last value in HUNT until a new match. locked is registered from state.
//   Latency: the payload word is complete on input word n+1. out_valid is asserted one cycle after that in_valid.
//   Counters saturate; no wrap. hits and misses never exceed their thresholds.
//   A reset asserted mid-frame clears everything immediately and asynchronously, including any pending out_valid.
//   Relock after reset takes the full LOCK_HITS sequence.
// TESTING
//   1 Aligned stream 81,A5,81,3C,81,5A,81,C3,81 with in_valid every 8th clk:
//     locked rises after the 3rd sync check, offset=0.
//     out_valid pulses carry 5A then C3. A5 and 3C are not emitted.
//   2 Same stream serialized with a 3-bit delay (prepend 3 zero bits, rechunk):
//     offset=3, locked asserts, out_data sequence matches test 1.
//   3 After lock, replace 4 consecutive syncs with 00:
//     sync_err pulses 4 times, locked falls after the 4th, out_valid stays low afterwards.
//   4 After lock, corrupt a single sync only:
//     one sync_err pulse, locked stays 1, and the next good sync clears misses.
//     A 4th isolated error later does not drop lock.
//   5 Test-1 stream with random 0..20-cycle gaps in in_valid:
//     out_data/out_valid sequence is identical to test 1.
//     Nothing changes during the gaps.
//   6 Assert reset for 1 cycle while LOCKED mid-payload:
//     locked, out_valid, offset=0 immediately, with no out_valid on the following edge.
//     Relock after 3 further sync checks.
//     False sync, HUNT entered on payload 81: VERIFY mismatch returns to HUNT without emitting data.

Source files
------------

// File: rtl/serdes_word_aligner_if.sv
`default_nettype none
// ============================================================================
// Module      : serdes_word_aligner_if
// Description : Word stream in, aligned payload and lock status out.
// Revision    : 1.0 - initial release
// ============================================================================
interface serdes_word_aligner_if #(
    parameter int WIDTH = 8,
    parameter int OFS_W = 3
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             locked;
    logic [OFS_W-1:0] offset;
    logic             sync_err;

    modport master (
        output in_data, in_valid,
        input  out_data, out_valid, locked, offset, sync_err
    );

    modport slave (
        input  in_data, in_valid,
        output out_data, out_valid, locked, offset, sync_err
    );
endinterface
`default_nettype wire

// File: rtl/serdes_word_aligner.sv
`default_nettype none
// ============================================================================
// Module      : serdes_word_aligner
// Description : Finds SYNC_WORD at any bit offset in the serdes word stream,
//               locks after LOCK_HITS spaced syncs and emits aligned payload.
// Revision    : 1.0 - initial release
// ============================================================================
module serdes_word_aligner #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD   = 8'h81,
    parameter int               FRAME_LEN   = 1,
    parameter int               LOCK_HITS   = 3,
    parameter int               LOSS_MISSES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    serdes_word_aligner_if.slave    bus
);

    localparam int OFS_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SLOT_W = $clog2(FRAME_LEN + 1);
    localparam int HIT_W  = $clog2(LOCK_HITS + 1);
    localparam int MISS_W = $clog2(LOSS_MISSES + 1);

    localparam logic [SLOT_W-1:0] c_frame_len   = SLOT_W'(FRAME_LEN);
    localparam logic [SLOT_W-1:0] c_slot_one    = SLOT_W'(1);
    localparam logic [HIT_W-1:0]  c_lock_hits   = HIT_W'(LOCK_HITS);
    localparam logic [HIT_W-1:0]  c_hits_one    = HIT_W'(1);
    localparam logic [MISS_W-1:0] c_loss_misses = MISS_W'(LOSS_MISSES);
    localparam logic [MISS_W-1:0] c_miss_one    = MISS_W'(1);

    localparam logic [1:0] c_st_hunt   = 2'd0;
    localparam logic [1:0] c_st_verify = 2'd1;
    localparam logic [1:0] c_st_locked = 2'd2;

    logic [1:0]        r_state;
    logic [WIDTH-1:0]  r_prev;
    logic              r_primed;
    logic [SLOT_W-1:0] r_slot;
    logic [HIT_W-1:0]  r_hits;
    logic [MISS_W-1:0] r_misses;
    logic [OFS_W-1:0]  r_offset;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_valid;
    logic              r_locked;
    logic              r_sync_err;

    logic [2*WIDTH-1:0] w_window;
    logic [WIDTH-1:0]   w_cand [WIDTH];
    logic [WIDTH-1:0]   w_match;
    logic               w_hit;
    logic [OFS_W-1:0]   w_hit_k;
    logic [WIDTH-1:0]   w_aligned;
    logic               w_sync_ok;
    logic               w_sync_pos;
    logic [SLOT_W-1:0]  w_slot_nxt;
    logic [HIT_W-1:0]   w_hits_inc;
    logic [MISS_W-1:0]  w_misses_inc;

    // Candidate k starts k bits into the previous word, so k=0 is prev itself.
    assign w_window = {r_prev, bus.in_data};

    genvar k;
    generate
        for (k = 0; k < WIDTH; k++) begin : g_cand
            assign w_cand[k]  = w_window[2*WIDTH-1-k -: WIDTH];
            assign w_match[k] = (w_cand[k] == SYNC_WORD);
        end
    endgenerate

    always_comb begin
        w_hit   = 1'b0;
        w_hit_k = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit   = 1'b1;
                w_hit_k = OFS_W'(i);
            end
        end
    end

    assign w_aligned    = w_cand[r_offset];
    assign w_sync_ok    = (w_aligned == SYNC_WORD);
    assign w_sync_pos   = (r_slot == '0);
    assign w_slot_nxt   = (r_slot == c_frame_len) ? '0 : r_slot + c_slot_one;
    assign w_hits_inc   = r_hits + c_hits_one;
    assign w_misses_inc = r_misses + c_miss_one;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_st_hunt;
            r_prev      <= '0;
            r_primed    <= 1'b0;
            r_slot      <= '0;
            r_hits      <= '0;
            r_misses    <= '0;
            r_offset    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
            if (bus.in_valid) begin
                r_prev   <= bus.in_data;
                r_primed <= 1'b1;
                if (r_primed) begin
                    case (r_state)
                        c_st_hunt: begin
                            if (w_hit) begin
                                r_offset <= w_hit_k;
                                r_slot   <= c_slot_one;
                                r_hits   <= c_hits_one;
                                r_state  <= c_st_verify;
                            end
                        end
                        c_st_verify: begin
                            r_slot <= w_slot_nxt;
                            // Payload is withheld here so a sync-like payload word cannot leak out.
                            if (w_sync_pos) begin
                                if (w_sync_ok) begin
                                    r_hits <= w_hits_inc;
                                    if (w_hits_inc >= c_lock_hits) begin
                                        r_hits   <= c_lock_hits;
                                        r_misses <= '0;
                                        r_state  <= c_st_locked;
                                        r_locked <= 1'b1;
                                    end
                                end else begin
                                    r_hits  <= '0;
                                    r_state <= c_st_hunt;
                                end
                            end
                        end
                        c_st_locked: begin
                            r_slot <= w_slot_nxt;
                            if (w_sync_pos) begin
                                if (w_sync_ok) begin
                                    r_misses <= '0;
                                end else begin
                                    r_sync_err <= 1'b1;
                                    r_misses   <= w_misses_inc;
                                    if (w_misses_inc >= c_loss_misses) begin
                                        r_misses <= c_loss_misses;
                                        r_hits   <= '0;
                                        r_state  <= c_st_hunt;
                                        r_locked <= 1'b0;
                                    end
                                end
                            end else begin
                                r_out_data  <= w_aligned;
                                r_out_valid <= 1'b1;
                            end
                        end
                        default: begin
                            r_state  <= c_st_hunt;
                            r_locked <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.locked    = r_locked;
    assign bus.offset    = r_offset;
    assign bus.sync_err  = r_sync_err;

endmodule
`default_nettype wire
